// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles little-endian 32-bit words
// from a byte stream and holds the core in reset until the load completes.
module imem_loader #(
  parameter int INSTR_LEN = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [ADDR_W:0]      word_count,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [INSTR_LEN-1:0] imem_wdata,
  output logic                 cpu_reset,
  output logic                 load_done,
  output logic                 load_error
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t          state, state_nx;
  logic [ADDR_W:0] count, idx;
  logic [1:0]      bcnt;
  logic [23:0]     asm_word;
  logic            start_seen, start_ok, take;

  assign start_seen = load_start && (state == IDLE || state == DONE);
  assign start_ok   = (word_count != '0) && (word_count <= DEPTH_W);
  assign take       = (state == COLLECT) && byte_valid;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (load_start) state_nx = start_ok ? COLLECT : IDLE;
      COLLECT:    if (byte_valid && bcnt == 2'd3) state_nx = WRITE;
      WRITE:      state_nx = (idx == count - ONE) ? DONE : COLLECT;
      default:    state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      idx        <= '0;
      bcnt       <= '0;
      asm_word   <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_ready <= (state_nx == COLLECT);
      imem_we    <= (state_nx == WRITE);
      cpu_reset  <= (state_nx != DONE);
      load_done  <= (state_nx == DONE);

      if (start_seen) begin
        if (start_ok) begin
          count      <= word_count;
          idx        <= '0;
          bcnt       <= '0;
          load_error <= 1'b0;
        end else begin
          load_error <= 1'b1;
        end
      end

      if (take) begin
        bcnt <= bcnt + 2'd1;
        case (bcnt)
          2'd0:    asm_word[7:0]   <= byte_in;
          2'd1:    asm_word[15:8]  <= byte_in;
          2'd2:    asm_word[23:16] <= byte_in;
          default: begin
            imem_addr  <= idx[ADDR_W-1:0];
            imem_wdata <= {byte_in, asm_word};
          end
        endcase
      end

      if (state == WRITE) begin
        idx  <= idx + ONE;
        bcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start-check vector table, directed
// corner sequences, and randomized loads against a byte-list word model.
module tb_imem_loader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [6:0]  word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, imem_we, cpu_reset, load_done, load_error;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int we_dbl = 0;
  logic prev_we = 1'b0;
  logic [37:0] wr_q[$];
  logic [7:0]  bq[$];

  imem_loader #(.INSTR_LEN(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
    if (imem_we && prev_we) we_dbl++;
    prev_we = imem_we;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic start(input int wc);
    load_start = 1'b1; word_count = 7'(wc);
    tick();
    load_start = 1'b0;
  endtask

  // gap: 0 = valid held high, 1 = valid pattern 1,0,0, 2 = random valid plus
  // stray load_start pulses that the loader must ignore while collecting.
  task automatic drive_stream(input int gap);
    int k = 0;
    bit acc;
    while (bq.size() != 0 && k < 4000) begin
      case (gap)
        0:       byte_valid = 1'b1;
        1:       byte_valid = (k % 3 == 0);
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      if (gap == 2) begin
        load_start = ($urandom_range(0, 7) == 0);
        word_count = 7'($urandom_range(0, 127));
      end
      byte_in = bq[0];
      @(negedge clk);
      acc = byte_valid && byte_ready;
      tick();
      if (acc) void'(bq.pop_front());
      k++;
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
    check("stream_timeout", 64'(bq.size()), 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!load_done && n < 2000) begin tick(); n++; end
    check("done_timeout", 64'(load_done), 64'd1);
  endtask

  // Expected writes: word i is bytes 4i..4i+3 little-endian, at address i.
  task automatic run_load(input string nm, input int wc, input int gap,
                          input bit lag, output int lat);
    logic [37:0] exp[$];
    int t0;
    for (int w = 0; w < wc; w++)
      exp.push_back({6'(w), bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]});
    wr_q.delete();
    start(wc);
    check({nm, "_ready"}, 64'(byte_ready), 64'd1);
    check({nm, "_err_clr"}, 64'(load_error), 64'd0);
    check({nm, "_cpu_rst_hold"}, 64'(cpu_reset), 64'd1);
    t0 = cyc;
    if (lag) tick();
    drive_stream(gap);
    wait_done();
    lat = cyc - t0;
    check({nm, "_cpu_rst_rel"}, 64'(cpu_reset), 64'd0);
    check({nm, "_nwrites"}, 64'(wr_q.size()), 64'(wc));
    for (int i = 0; i < wc && i < wr_q.size(); i++)
      check($sformatf("%s_w%0d", nm, i), 64'(wr_q[i]), 64'(exp[i]));
  endtask

  typedef struct {
    int   wc;
    logic exp_err;
    logic exp_ready;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int lat;
    vecs[0] = '{0, 1'b1, 1'b0};
    vecs[1] = '{65, 1'b1, 1'b0};
    vecs[2] = '{127, 1'b1, 1'b0};
    vecs[3] = '{1, 1'b0, 1'b1};
    vecs[4] = '{64, 1'b0, 1'b1};
    vecs[5] = '{33, 1'b0, 1'b1};

    do_reset();
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_error", 64'(load_error), 64'd0);

    // load_start acceptance table
    foreach (vecs[i]) begin
      do_reset();
      wr_q.delete();
      start(vecs[i].wc);
      check($sformatf("vec%0d_err", i), 64'(load_error), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_ready", i), 64'(byte_ready), 64'(vecs[i].exp_ready));
      tick(); tick(); tick();
      check($sformatf("vec%0d_err_sticky", i), 64'(load_error), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_nowrite", i), 64'(wr_q.size()), 64'd0);
      check($sformatf("vec%0d_cpu_rst", i), 64'(cpu_reset), 64'd1);
    end

    // Single word; producer reacts one cycle after seeing byte_ready
    do_reset();
    bq = '{8'h20, 8'h00, 8'h80, 8'hD2};
    run_load("single", 1, 0, 1'b1, lat);
    check("single_lat", 64'(lat), 64'd6);
    check("single_word", 64'(wr_q.size() > 0 ? wr_q[0] : 38'h0), 64'({6'd0, 32'hD2800020}));

    // Full depth, valid held high: 5N cycles
    do_reset();
    for (int i = 0; i < 4*DEPTH; i++) bq.push_back(8'(i));
    run_load("full", DEPTH, 0, 1'b0, lat);
    check("full_lat", 64'(lat), 64'(5*DEPTH));
    check("full_last_addr", 64'(wr_q.size() == DEPTH ? wr_q[DEPTH-1][37:32] : 6'h0), 64'd63);

    // Backpressure gaps
    do_reset();
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    run_load("gaps", 2, 1, 1'b0, lat);

    // Invalid counts, then a valid start clears the error
    do_reset();
    wr_q.delete();
    start(0);
    check("inv0_err", 64'(load_error), 64'd1);
    tick();
    start(65);
    check("inv65_err", 64'(load_error), 64'd1);
    check("inv65_ready", 64'(byte_ready), 64'd0);
    start(2);
    check("inv_then_ok_err", 64'(load_error), 64'd0);
    check("inv_then_ok_ready", 64'(byte_ready), 64'd1);
    check("inv_nowrite", 64'(wr_q.size()), 64'd0);

    // Reset after one word plus two bytes
    do_reset();
    wr_q.delete();
    start(3);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    drive_stream(0);
    check("midrst_cpu_rst_pre", 64'(cpu_reset), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ready", 64'(byte_ready), 64'd0);
    check("midrst_cpu_rst", 64'(cpu_reset), 64'd1);
    check("midrst_done", 64'(load_done), 64'd0);
    tick(); tick(); tick(); tick(); tick();
    check("midrst_nwrites", 64'(wr_q.size()), 64'd1);
    check("midrst_w0", 64'(wr_q.size() > 0 ? wr_q[0] : 38'h0), 64'({6'd0, 32'h04030201}));

    // Reload from DONE
    do_reset();
    bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("reload_a", 1, 0, 1'b0, lat);
    bq = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    run_load("reload_b", 2, 0, 1'b0, lat);
    check("reload_b_done", 64'(load_done), 64'd1);

    // Randomized loads, with occasional invalid restarts from DONE
    do_reset();
    for (int it = 0; it < 12; it++) begin
      int wc;
      wc = ($urandom_range(0, 5) == 0) ? $urandom_range(9, DEPTH) : $urandom_range(1, 8);
      bq.delete();
      for (int b = 0; b < 4*wc; b++) bq.push_back(8'($urandom));
      run_load($sformatf("rnd%0d", it), wc, 2, 1'b0, lat);
      if ($urandom_range(0, 2) == 0) begin
        start(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH+1, 127));
        check($sformatf("rnd%0d_bad_err", it), 64'(load_error), 64'd1);
        check($sformatf("rnd%0d_bad_done", it), 64'(load_done), 64'd0);
        check($sformatf("rnd%0d_bad_cpu_rst", it), 64'(cpu_reset), 64'd1);
        check($sformatf("rnd%0d_bad_ready", it), 64'(byte_ready), 64'd0);
      end
    end

    check("we_never_consecutive", 64'(we_dbl), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
